// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: assembles little-endian byte pairs
// into 16-bit words and writes them to word-aligned byte addresses.
`timescale 1ns/1ps
module imem_loader #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [8:0]  word_count,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        abort,
  output logic [8:0]  words_loaded
);

  localparam int unsigned AW    = 16;
  localparam int unsigned CW    = 9;
  localparam int unsigned BW    = 8;
  localparam int unsigned SUM_W = 18;

  typedef enum logic [2:0] {IDLE, GET_LO, GET_HI, WRITE, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic [CW-1:0]   words_q, words_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic            wr_en_q, wr_en_d, error_q, error_d;
  logic            done_q, done_d, busy_q, busy_d, in_ready_q, in_ready_d;
  logic [SUM_W-1:0] end_addr_c;
  logic            start_ok_c, xfer_c;

  // Bounds check is done in 18 bits so base + 4*count cannot wrap.
  assign end_addr_c = SUM_W'(base_addr) + (SUM_W'(word_count) << 2);
  assign start_ok_c = (base_addr[1:0] == 2'b00) && (end_addr_c <= SUM_W'(MEM_SIZE));
  assign xfer_c     = in_valid && in_ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      words_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      words_q    <= words_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      error_q    <= error_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Abort outranks the byte handshake in every loading state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && start_ok_c) state_d = (word_count == '0) ? DONE : GET_LO;
      GET_LO:  if (abort) state_d = IDLE; else if (xfer_c) state_d = GET_HI;
      GET_HI:  if (abort) state_d = IDLE; else if (xfer_c) state_d = WRITE;
      WRITE:   if (abort) state_d = IDLE;
               else state_d = ((words_q + CW'(1)) == count_q) ? DONE : GET_LO;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The write commits as WRITE is left, so an abort seen in WRITE cancels it.
  always_comb begin
    addr_d     = addr_q;
    count_d    = count_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    words_d    = words_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    error_d    = error_q;
    wr_en_d    = 1'b0;
    done_d     = (state_d == DONE);
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == GET_LO) || (state_d == GET_HI);
    unique case (state_q)
      IDLE: begin
        if (start && start_ok_c) begin
          addr_d  = base_addr;
          count_d = word_count;
          words_d = '0;
          error_d = 1'b0;
        end else if (start) begin
          error_d = 1'b1;
        end
      end
      GET_LO: begin
        if (abort)       error_d = 1'b1;
        else if (xfer_c) lo_d    = in_data;
      end
      GET_HI: begin
        if (abort)       error_d = 1'b1;
        else if (xfer_c) hi_d    = in_data;
      end
      WRITE: begin
        if (abort) begin
          error_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {hi_q, lo_q};
          addr_d    = addr_q + AW'(4);
          words_d   = words_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign in_ready     = in_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, meaning the target instruction memory size in bytes (power of two, >4).
REQ-002 SHALL have port clk  in  1  meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  meaning the synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  meaning a load request, sampled only in IDLE.
REQ-005 SHALL have port base_addr  in  16  meaning the first byte address to write, which must be word-aligned.
REQ-006 SHALL have port word_count  in  9  meaning the number of 16-bit instructions to load (0..256).
REQ-007 SHALL have ports in_data  in  8, in_valid  in  1 and in_ready  out  1, forming the byte-stream handshake; a byte transfers when in_valid and in_ready are both 1.
REQ-008 SHALL have ports wr_en  out  1, wr_addr  out  16 and wr_data  out  16, forming the instruction-memory write port.
REQ-009 SHALL have port busy  out  1, high in every state except IDLE.
REQ-010 SHALL have port done  out  1, a one-cycle completion pulse.
REQ-011 SHALL have port error  out  1, a sticky failure flag.
REQ-012 SHALL have port abort  in  1, which cancels an active load.
REQ-013 SHALL have port words_loaded  out  9, counting words written in the current or last load.

Function
REQ-014 SHALL implement the states IDLE, GET_LO, GET_HI, WRITE and DONE.
REQ-015 On start in IDLE, SHALL latch base_addr and word_count, clear error and words_loaded, and check that base_addr[1:0]==0 and base_addr + 4*word_count <= MEM_SIZE, using at least an 18-bit sum so it cannot overflow.
REQ-016 If the start check fails, SHALL stay in IDLE, set error=1 on the next cycle, and assert no wr_en.
REQ-017 If the start check passes with word_count==0, SHALL enter DONE directly, with no writes.
REQ-018 If the start check passes with word_count>0, SHALL enter GET_LO with the current address set to base_addr.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 SHALL drive in_ready=1 only in GET_LO and GET_HI.
REQ-021 In GET_LO, SHALL capture the low byte on transfer and move to GET_HI; with no transfer it stays in GET_LO.
REQ-022 In GET_HI, SHALL capture the high byte on transfer and move to WRITE; with no transfer it stays in GET_HI.
REQ-023 In WRITE, SHALL assert wr_en for exactly one cycle with wr_addr=current address and wr_data={high byte, low byte}.
REQ-024 In WRITE, SHALL then add 4 to the current address (byte addressing; the memory indexes by address/4) and increment words_loaded.
REQ-025 From WRITE, SHALL go to DONE if words_loaded reaches word_count, otherwise to GET_LO.
REQ-026 In DONE, SHALL pulse done=1 for one cycle, then return to IDLE; words_loaded holds its value until the next accepted start.
REQ-027 Minimum throughput SHALL be one word per 3 cycles; stalls on in_valid SHALL NOT corrupt the captured bytes.
REQ-028 Every wr_addr SHALL satisfy wr_addr[1:0]==0 and wr_addr+3 < MEM_SIZE.
REQ-029 Abort in GET_LO, GET_HI or WRITE SHALL take priority over the handshake: the state goes to IDLE and error=1 on the next cycle.
REQ-030 On abort, SHALL suppress wr_en in that cycle, discard any partial word, and not pulse done.
REQ-031 Abort in IDLE or DONE SHALL be ignored.
REQ-032 wr_addr and wr_data SHALL hold their last values when wr_en=0.

Reset
REQ-033 Reset SHALL take priority over all inputs, including start and abort.
REQ-034 Reset SHALL force IDLE with in_ready, wr_en, busy, done and error all 0, and wr_addr, wr_data and words_loaded all 0.
REQ-035 Reset mid-load SHALL discard any partial word and suppress wr_en in the reset cycle.
REQ-036 The first load after reset SHALL behave identically to a load from power-up.

Verification
REQ-037 SHALL cover a basic two-word load: start, base 0x0000, count 2, bytes 34,12,78,56 with in_valid held high -> wr_en at 0x0000 with 0x1234, then at 0x0004 with 0x5678; done pulses once; words_loaded=2; busy=0 afterward.
REQ-038 SHALL cover a misaligned base: base 0x0002, count 1 -> error=1, no wr_en, busy=0.
REQ-039 SHALL cover the upper bound: base 0x03FC, count 1 -> one write at 0x03FC and done; base 0x03FC, count 2 -> error=1 and no write.
REQ-040 SHALL cover stream gaps: in_valid low for 5 cycles between the low and high bytes of 0xBEEF -> exactly one write with 0xBEEF, after the high byte.
REQ-041 SHALL cover reset mid-word: reset in GET_HI after the low byte 0xAA -> all outputs 0; a new load of bytes 11,22 writes 0x2211.
REQ-042 SHALL cover the edge cases: count 0 -> done pulse with no writes; start while busy -> ignored; abort in GET_HI -> error=1, no write, no done.
